// File: rtl/viterbi_ctrl_pkg.sv
// Shared state encoding, counter sizing and default geometry for the Viterbi frame sequencer.
package viterbi_ctrl_pkg;

    localparam int unsigned DefFrameLen = 256;
    localparam int unsigned DefTailLen  = 6;
    localparam int unsigned DefDecLat   = 64;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StLoad  = 3'd1;
    localparam state_t StTail  = 3'd2;
    localparam state_t StDrain = 3'd3;
    localparam state_t StDone  = 3'd4;

    function automatic int unsigned cnt_width(input int unsigned frame_len,
                                              input int unsigned tail_len);
        return $clog2(frame_len + tail_len + 1);
    endfunction

endpackage

// File: rtl/viterbi_tag_dly.sv
// DEPTH-stage {valid, tag} shift register tracking decoder latency; tap is the last stage.
module viterbi_tag_dly #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic push_i,
    input  logic tag_i,
    output logic valid_o,
    output logic tag_o
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] tag_q, tag_d;

    always_comb begin
        valid_d = (valid_q << 1) | DEPTH'(push_i);
        tag_d   = (tag_q << 1) | DEPTH'(push_i & tag_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else if (clr_i) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign tag_o   = tag_q[DEPTH-1];

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer: payload load, zero-tail termination, decoder tagging and payload output.
// Optional watchdog abort enabled by defining VITERBI_FRAME_WDOG_EN.
module viterbi_frame_ctrl
    import viterbi_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_LEN = DefFrameLen,
    parameter int unsigned TAIL_LEN  = DefTailLen,
    parameter int unsigned DEC_LAT   = DefDecLat,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o,
    output logic done_o,
    input  logic src_valid_i,
    input  logic src_data_i,
    output logic src_ready_o,
    output logic enc_enable_o,
    output logic enc_data_o,
    input  logic enc_valid_i,
    output logic dec_enable_o,
    input  logic dec_data_i,
    output logic out_valid_o,
    output logic out_data_o,
    output logic err_o
);

    localparam int unsigned CW = cnt_width(FRAME_LEN, TAIL_LEN);
    localparam logic [CW-1:0] FrameCnt = CW'(FRAME_LEN);
    localparam logic [CW-1:0] LastIn   = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] TailLast = CW'((TAIL_LEN == 0) ? 0 : TAIL_LEN - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [CW-1:0] tail_cnt_q, tail_cnt_d;
    logic [CW-1:0] dec_cnt_q, dec_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          enc_enable_q, enc_enable_d;
    logic          enc_data_q, enc_data_d;
    logic          dec_enable_q, dec_enable_d;

    logic active, hs, push, push_tag, tap_valid, tap_tag, out_fire, abort;

    assign active   = (state_q != StIdle);
    assign hs       = src_valid_i & src_ready_o;
    assign push     = dec_enable_q & active;
    assign push_tag = (dec_cnt_q < FrameCnt);
    assign out_fire = active & tap_valid & tap_tag;

    viterbi_tag_dly #(
        .DEPTH (DEC_LAT)
    ) u_tag_dly (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (~active | abort),
        .push_i  (push),
        .tag_i   (push_tag),
        .valid_o (tap_valid),
        .tag_o   (tap_tag)
    );

`ifdef VITERBI_FRAME_WDOG_EN
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] pend_q, pend_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          wd_run, wd_fire;

    // Runs only while encoder outputs are owed, i.e. more enables issued than valids returned.
    assign wd_run  = ((state_q == StLoad) || (state_q == StTail) || (state_q == StDrain)) &&
                     (pend_q != '0);
    assign wd_fire = ~enc_valid_i & wd_run & (wd_q == WW'(TIMEOUT - 1));

    always_comb begin
        pend_d = pend_q + CW'(enc_enable_q) - CW'(enc_valid_i);
        wd_d   = wd_q;
        if (!active || wd_fire) begin
            pend_d = '0;
            wd_d   = '0;
        end else if (enc_valid_i) begin
            wd_d = '0;
        end else if (wd_run) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            wd_q   <= '0;
        end else begin
            pend_q <= pend_d;
            wd_q   <= wd_d;
        end
    end

    assign abort = wd_fire;
    assign err_o = wd_fire;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign abort = 1'b0;
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        tail_cnt_d   = tail_cnt_q;
        dec_cnt_d    = dec_cnt_q;
        out_cnt_d    = out_cnt_q;
        enc_enable_d = 1'b0;
        enc_data_d   = 1'b0;
        dec_enable_d = active & enc_valid_i;

        if (push) dec_cnt_d = dec_cnt_q + 1'b1;
        if (out_fire) out_cnt_d = out_cnt_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                in_cnt_d   = '0;
                tail_cnt_d = '0;
                dec_cnt_d  = '0;
                out_cnt_d  = '0;
                if (start_i) state_d = StLoad;
            end
            StLoad: begin
                if (hs) begin
                    enc_enable_d = 1'b1;
                    enc_data_d   = src_data_i;
                    in_cnt_d     = in_cnt_q + 1'b1;
                    if (in_cnt_q == LastIn) state_d = (TAIL_LEN == 0) ? StDrain : StTail;
                end
            end
            StTail: begin
                enc_enable_d = 1'b1;
                tail_cnt_d   = tail_cnt_q + 1'b1;
                if (tail_cnt_q == TailLast) state_d = StDrain;
            end
            StDrain: begin
                // Look ahead on the final output so done lands in the very next cycle.
                if ((out_cnt_q == FrameCnt) || (out_fire && (out_cnt_q == LastIn))) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d      = StIdle;
            in_cnt_d     = '0;
            tail_cnt_d   = '0;
            dec_cnt_d    = '0;
            out_cnt_d    = '0;
            enc_enable_d = 1'b0;
            enc_data_d   = 1'b0;
            dec_enable_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            in_cnt_q     <= '0;
            tail_cnt_q   <= '0;
            dec_cnt_q    <= '0;
            out_cnt_q    <= '0;
            enc_enable_q <= 1'b0;
            enc_data_q   <= 1'b0;
            dec_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            tail_cnt_q   <= tail_cnt_d;
            dec_cnt_q    <= dec_cnt_d;
            out_cnt_q    <= out_cnt_d;
            enc_enable_q <= enc_enable_d;
            enc_data_q   <= enc_data_d;
            dec_enable_q <= dec_enable_d;
        end
    end

    assign busy_o       = active;
    assign done_o       = (state_q == StDone);
    assign src_ready_o  = (state_q == StLoad);
    assign enc_enable_o = enc_enable_q;
    assign enc_data_o   = enc_data_q;
    assign dec_enable_o = dec_enable_q;
    assign out_valid_o  = out_fire;
    assign out_data_o   = out_fire & dec_data_i;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl with a loopback encoder and fixed-latency decoder model.
module tb_viterbi_frame_ctrl;

    localparam int unsigned FL = 8;
    localparam int unsigned TL = 6;
    localparam int unsigned DL = 4;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i, src_valid_i, src_data_i;
    logic busy_o, done_o, src_ready_o, enc_enable_o, enc_data_o, dec_enable_o;
    logic out_valid_o, out_data_o, err_o;
    logic enc_valid_i, dec_data_i;

    always #5 clk = ~clk;

    viterbi_frame_ctrl #(
        .FRAME_LEN (FL),
        .TAIL_LEN  (TL),
        .DEC_LAT   (DL),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .src_valid_i  (src_valid_i),
        .src_data_i   (src_data_i),
        .src_ready_o  (src_ready_o),
        .enc_enable_o (enc_enable_o),
        .enc_data_o   (enc_data_o),
        .enc_valid_i  (enc_valid_i),
        .dec_enable_o (dec_enable_o),
        .dec_data_i   (dec_data_i),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .err_o        (err_o)
    );

    // Encoder: valid one cycle after enable. Decoder: bit appears DL cycles after dec_enable.
    logic          en_dly = 1'b0;
    logic [DL+1:0] data_pipe = '0;
    bit            stall_en = 1'b0;
    int            vcnt = 0;

    assign enc_valid_i = en_dly & ~(stall_en && (vcnt >= 3));
    assign dec_data_i  = data_pipe[DL+1];

    always @(posedge clk) begin
        en_dly    <= enc_enable_o;
        data_pipe <= {data_pipe[DL:0], enc_data_o};
        if (!stall_en) vcnt <= 0;
        else if (enc_valid_i) vcnt <= vcnt + 1;
    end

    int   n_tests = 0;
    int   n_fail = 0;
    int   n_out = 0;
    int   n_done = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_v_cyc = 0;
    int   err_cyc = 0;
    logic exp_q[$];
    logic enc_log[$];
    logic prev_ov = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every out_valid_o and checks done placement.
    always @(negedge clk) begin
        cyc++;
        if (enc_valid_i) last_v_cyc = cyc;
        if (err_o) begin
            n_err++;
            err_cyc = cyc;
        end
        if (enc_enable_o) enc_log.push_back(enc_data_o);
        if (out_valid_o) begin
            n_out++;
            if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
            else chk("out_data", int'(out_data_o), int'(exp_q.pop_front()));
        end
        if (done_o) begin
            n_done++;
            chk("done_follows_last_out", int'(prev_ov), 1);
            chk("done_queue_empty", exp_q.size(), 0);
        end
        prev_ov = out_valid_o;
    end

    task automatic send_frame(input logic [7:0] bits, input bit gaps, input bit start_mid,
                              input int n_send);
        int sent = 0;
        int budget = 0;
        bit hs;
        bit tog = 1'b0;
        for (int i = 0; i < FL; i++) exp_q.push_back(bits[FL-1-i]);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        while (sent < n_send && budget < 100) begin
            src_valid_i = gaps ? tog : 1'b1;
            tog = ~tog;
            src_data_i = bits[FL-1-sent];
            start_i = start_mid && (sent == 2);
            hs = src_valid_i && src_ready_o;
            @(posedge clk);
            #1;
            if (hs) sent++;
            budget++;
        end
        src_valid_i = 1'b0;
        src_data_i  = 1'b0;
        start_i     = 1'b0;
        if (sent < n_send) chk("src_handshake_timeout", sent, n_send);
    endtask

    task automatic wait_done(input bit start_in_done);
        int k = 0;
        while (!done_o && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!done_o) chk("done_timeout", 0, 1);
        else if (start_in_done) begin
            start_i = 1'b1;
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] pat2;
        int base_o;
        int base_d;
        pat  = 8'b10110010;
        pat2 = 8'b01101001;
        start_i     = 1'b0;
        src_valid_i = 1'b0;
        src_data_i  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_ready", int'(src_ready_o), 0);
        chk("rst_enc_en", int'(enc_enable_o), 0);
        chk("rst_dec_en", int'(dec_enable_o), 0);
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_err", int'(err_o), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Continuous-valid frame.
        enc_log.delete();
        base_o = n_out;
        base_d = n_done;
        send_frame(pat, 1'b0, 1'b0, FL);
        wait_done(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t1_busy_low", int'(busy_o), 0);
        chk("t1_out_count", n_out - base_o, FL);
        chk("t1_done_count", n_done - base_d, 1);
        chk("t1_enc_count", enc_log.size(), FL + TL);
        for (int i = 0; i < enc_log.size() && i < FL + TL; i++)
            chk("t1_enc_data", int'(enc_log[i]), (i < FL) ? int'(pat[FL-1-i]) : 0);

        // Alternate-cycle source valid.
        enc_log.delete();
        base_o = n_out;
        base_d = n_done;
        send_frame(pat, 1'b1, 1'b0, FL);
        wait_done(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t2_out_count", n_out - base_o, FL);
        chk("t2_done_count", n_done - base_d, 1);
        chk("t2_enc_count", enc_log.size(), FL + TL);

        // start_i pulsed in LOAD and in DONE.
        base_o = n_out;
        base_d = n_done;
        send_frame(pat2, 1'b0, 1'b1, FL);
        wait_done(1'b1);
        repeat (40) @(posedge clk);
        #1;
        chk("t3_busy_low", int'(busy_o), 0);
        chk("t3_out_count", n_out - base_o, FL);
        chk("t3_done_count", n_done - base_d, 1);

        // Reset mid-LOAD after three bits, then a clean frame.
        base_o = n_out;
        base_d = n_done;
        send_frame(pat, 1'b0, 1'b0, 3);
        rst = 1'b1;
        #1;
        chk("t4_busy", int'(busy_o), 0);
        chk("t4_ready", int'(src_ready_o), 0);
        chk("t4_enc_en", int'(enc_enable_o), 0);
        chk("t4_dec_en", int'(dec_enable_o), 0);
        chk("t4_done", int'(done_o), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t4_no_done", n_done - base_d, 0);
        chk("t4_no_out", n_out - base_o, 0);
        send_frame(pat2, 1'b0, 1'b0, FL);
        wait_done(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_out_count", n_out - base_o, FL);
        chk("t4_done_count", n_done - base_d, 1);

        // Back-to-back frames.
        base_o = n_out;
        base_d = n_done;
        send_frame(pat, 1'b0, 1'b0, FL);
        wait_done(1'b0);
        @(posedge clk);
        #1;
        send_frame(pat2, 1'b0, 1'b0, FL);
        wait_done(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_out_count", n_out - base_o, 2 * FL);
        chk("t5_done_count", n_done - base_d, 2);

`ifdef VITERBI_FRAME_WDOG_EN
        // Encoder stalls after three valids; watchdog must abort the frame.
        begin
            int k;
            k = 0;
            base_o = n_out;
            base_d = n_done;
            stall_en = 1'b1;
            @(posedge clk);
            #1;
            send_frame(pat, 1'b0, 1'b0, FL);
            while (!err_o && k < 100) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("t6_err_seen", int'(err_o), 1);
            @(posedge clk);
            #1;
            chk("t6_err_delay", err_cyc - last_v_cyc, TO);
            chk("t6_err_count", n_err, 1);
            chk("t6_busy_low", int'(busy_o), 0);
            repeat (20) @(posedge clk);
            #1;
            chk("t6_no_done", n_done - base_d, 0);
            chk("t6_out_count", n_out - base_o, 3);
            exp_q.delete();
            stall_en = 1'b0;
        end
`else
        chk("err_never", n_err, 0);
`endif

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
